// File: rtl/mesh_pkg.sv
// Shared constants for 2D-mesh link endpoints: flit/bus widths, link bus bit layout and port directions.
package mesh_pkg;

  localparam int unsigned DATA_SIZE     = 37;
  localparam int unsigned PORT_SIZE     = DATA_SIZE + 2;

  localparam int unsigned LINK_READY    = 0;
  localparam int unsigned LINK_VALID    = 1;
  localparam int unsigned LINK_DATA_LSB = 2;

  typedef enum logic [1:0] {
    DIR_E = 2'd0,
    DIR_S = 2'd1,
    DIR_W = 2'd2,
    DIR_N = 2'd3
  } mesh_dir_e;

endpackage

// File: rtl/mesh_sync_fifo.sv
// Single-clock FIFO with registered ready/valid; ready stays low until the first edge after reset release.
module mesh_sync_fifo #(
  parameter int unsigned DATA_SIZE = 37,
  parameter int unsigned DEPTH     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic [DATA_SIZE-1:0] push_data,
  input  logic                 pop,
  output logic                 ready,
  output logic                 valid,
  output logic [DATA_SIZE-1:0] head
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_SIZE-1:0] mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [AW:0]          count;
  logic                 live;
  logic                 push_ok;
  logic                 pop_ok;

  // Both flags come from registers only, so no input-to-output path exists.
  assign ready   = live && (count != (AW+1)'(DEPTH));
  assign valid   = (count != '0);
  assign head    = mem[rd_ptr];
  assign push_ok = push && ready;
  assign pop_ok  = pop && valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      live   <= 1'b0;
    end else begin
      live <= 1'b1;
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mesh_link_port.sv
// One directional mesh link endpoint: TX FIFO towards the neighbour, RX FIFO towards the router.
module mesh_link_port
  import mesh_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_SIZE-1:0] tx_data_i,
  input  logic                 tx_valid_i,
  output logic                 tx_ready_o,
  output logic [DATA_SIZE-1:0] rx_data_o,
  output logic                 rx_valid_o,
  input  logic                 rx_ready_i,
  output logic [PORT_SIZE-1:0] link_o,
  input  logic [PORT_SIZE-1:0] link_i,
  output logic                 err_o
);

  logic                 tx_ready;
  logic                 tx_valid;
  logic [DATA_SIZE-1:0] tx_head;
  logic                 rx_ready;

  mesh_sync_fifo #(
    .DATA_SIZE (DATA_SIZE),
    .DEPTH     (DEPTH)
  ) u_tx_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (tx_valid_i),
    .push_data (tx_data_i),
    .pop       (link_i[LINK_READY]),
    .ready     (tx_ready),
    .valid     (tx_valid),
    .head      (tx_head)
  );

  mesh_sync_fifo #(
    .DATA_SIZE (DATA_SIZE),
    .DEPTH     (DEPTH)
  ) u_rx_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (link_i[LINK_VALID]),
    .push_data (link_i[PORT_SIZE-1:LINK_DATA_LSB]),
    .pop       (rx_ready_i),
    .ready     (rx_ready),
    .valid     (rx_valid_o),
    .head      (rx_data_o)
  );

  assign tx_ready_o = tx_ready;
  assign link_o     = {tx_head, tx_valid, rx_ready};

  // A neighbour flit offered while we are not ready is lost; remember it until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_o <= 1'b0;
    end else if (link_i[LINK_VALID] && !rx_ready) begin
      err_o <= 1'b1;
    end
  end

endmodule
